// File: rtl/video_param_regs_pkg.sv
// Shared word-address map and control-bit layout for the video parameter register block.
package video_param_regs_pkg;

    // Word addresses
    localparam int unsigned ADR_CORE_ID      = 32'h00;
    localparam int unsigned ADR_CORE_VERSION = 32'h01;
    localparam int unsigned ADR_CTL_UPDATE   = 32'h04;
    localparam int unsigned ADR_STATUS       = 32'h05;
    localparam int unsigned ADR_FRAME_COUNT  = 32'h06;
    localparam int unsigned ADR_TH           = 32'h10;
    localparam int unsigned ADR_INV          = 32'h11;
    localparam int unsigned ADR_MODE         = 32'h12;
    localparam int unsigned ADR_ACT_TH       = 32'h20;
    localparam int unsigned ADR_ACT_INV      = 32'h21;
    localparam int unsigned ADR_ACT_MODE     = 32'h22;

    // CTL_UPDATE / STATUS bit positions
    localparam int unsigned CTL_REQ_BIT        = 0;
    localparam int unsigned CTL_AUTO_BIT       = 1;
    localparam int unsigned STATUS_PENDING_BIT = 0;

endpackage

// File: rtl/video_param_wb_bytewrite.sv
// One software-writable register with per-byte-lane write enables.
module video_param_wb_bytewrite #(
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = '0,
    localparam int unsigned SEL_WIDTH = (WIDTH + 7) / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Merge enabled byte lanes of the write data over the held value
    always_comb begin
        value_d = value_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sel[i / 8]) begin
                value_d[i] = wdata[i];
            end
        end
    end

    // Register with synchronous reset; reset has priority over writes
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= INIT;
        end else if (wr_en) begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/video_param_wb_regs.sv
// Wishbone register block: shadow video parameters, copied to the active outputs only at
// an AXI4-Stream frame start so parameters never change mid-frame.
module video_param_wb_regs
    import video_param_regs_pkg::*;
#(
    parameter int unsigned WB_ADR_WIDTH = 8,
    parameter int unsigned WB_DAT_WIDTH = 32,
    localparam int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [31:0] CORE_ID = 32'h527a_2f10,
    parameter logic [31:0] CORE_VERSION = 32'h0000_0100,
    parameter logic [DATA_WIDTH-1:0] INIT_PARAM_TH = DATA_WIDTH'(127),
    parameter logic INIT_PARAM_INV = 1'b0,
    parameter logic [1:0] INIT_PARAM_MODE = 2'b10
) (
    input  logic                    s_wb_clk_i,
    input  logic                    s_wb_rst_i,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,
    input  logic                    s_axi4s_tuser,
    input  logic                    s_axi4s_tvalid,
    input  logic                    s_axi4s_tready,
    output logic [DATA_WIDTH-1:0]   out_param_th,
    output logic                    out_param_inv,
    output logic [1:0]              out_param_mode,
    output logic                    out_update
);

    logic                  wr_en;
    logic                  frame_start;
    logic                  load;
    logic                  th_wr;
    logic                  inv_wr;
    logic                  mode_wr;
    logic                  ctl_wr;
    logic [DATA_WIDTH-1:0] th_shadow;
    logic                  inv_shadow;
    logic [1:0]            mode_shadow;
    logic                  req_q;
    logic                  auto_q;
    logic [31:0]           frame_count_q;
    logic [DATA_WIDTH-1:0] th_active_q;
    logic                  inv_active_q;
    logic [1:0]            mode_active_q;
    logic                  update_q;
    logic [WB_DAT_WIDTH-1:0] rdata;
    logic                  unused_ok;

    // Zero-wait responder: every strobe is acknowledged in the same cycle
    assign s_wb_ack_o  = s_wb_stb_i;
    assign wr_en       = s_wb_stb_i & s_wb_we_i;
    assign frame_start = s_axi4s_tuser & s_axi4s_tvalid & s_axi4s_tready;
    // Load uses req as held before this edge, so a same-cycle write cannot alter the load
    assign load        = frame_start & (req_q | auto_q);

    assign th_wr   = wr_en && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_TH));
    assign inv_wr  = wr_en && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_INV));
    assign mode_wr = wr_en && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_MODE));
    assign ctl_wr  = wr_en && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL_UPDATE)) && s_wb_sel_i[0];

    video_param_wb_bytewrite #(
        .WIDTH (DATA_WIDTH),
        .INIT  (INIT_PARAM_TH)
    ) u_th (
        .clk   (s_wb_clk_i),
        .rst   (s_wb_rst_i),
        .wr_en (th_wr),
        .sel   (s_wb_sel_i[(DATA_WIDTH+7)/8-1:0]),
        .wdata (s_wb_dat_i[DATA_WIDTH-1:0]),
        .value (th_shadow)
    );

    video_param_wb_bytewrite #(
        .WIDTH (1),
        .INIT  (INIT_PARAM_INV)
    ) u_inv (
        .clk   (s_wb_clk_i),
        .rst   (s_wb_rst_i),
        .wr_en (inv_wr),
        .sel   (s_wb_sel_i[0]),
        .wdata (s_wb_dat_i[0]),
        .value (inv_shadow)
    );

    video_param_wb_bytewrite #(
        .WIDTH (2),
        .INIT  (INIT_PARAM_MODE)
    ) u_mode (
        .clk   (s_wb_clk_i),
        .rst   (s_wb_rst_i),
        .wr_en (mode_wr),
        .sel   (s_wb_sel_i[0]),
        .wdata (s_wb_dat_i[1:0]),
        .value (mode_shadow)
    );

    // Update request/auto flags; a software write beats the frame-start clear
    always_ff @(posedge s_wb_clk_i) begin
        if (s_wb_rst_i) begin
            req_q  <= 1'b0;
            auto_q <= 1'b0;
        end else if (ctl_wr) begin
            req_q  <= s_wb_dat_i[CTL_REQ_BIT];
            auto_q <= s_wb_dat_i[CTL_AUTO_BIT];
        end else if (load) begin
            req_q  <= 1'b0;
        end
    end

    // Count every qualifying frame start, wrapping naturally at 2^32
    always_ff @(posedge s_wb_clk_i) begin
        if (s_wb_rst_i) begin
            frame_count_q <= '0;
        end else if (frame_start) begin
            frame_count_q <= frame_count_q + 32'd1;
        end
    end

    // Copy shadow to active at a qualifying frame start and flag it for one cycle
    always_ff @(posedge s_wb_clk_i) begin
        if (s_wb_rst_i) begin
            th_active_q   <= INIT_PARAM_TH;
            inv_active_q  <= INIT_PARAM_INV;
            mode_active_q <= INIT_PARAM_MODE;
            update_q      <= 1'b0;
        end else begin
            update_q <= load;
            if (load) begin
                th_active_q   <= th_shadow;
                inv_active_q  <= inv_shadow;
                mode_active_q <= mode_shadow;
            end
        end
    end

    // Combinational read mux; unmapped addresses and unused bits read as zero
    always_comb begin
        rdata = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(ADR_CORE_ID):      rdata = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(ADR_CORE_VERSION): rdata = WB_DAT_WIDTH'(CORE_VERSION);
            WB_ADR_WIDTH'(ADR_CTL_UPDATE):   rdata = WB_DAT_WIDTH'({auto_q, req_q});
            WB_ADR_WIDTH'(ADR_STATUS):       rdata = WB_DAT_WIDTH'(req_q);
            WB_ADR_WIDTH'(ADR_FRAME_COUNT):  rdata = WB_DAT_WIDTH'(frame_count_q);
            WB_ADR_WIDTH'(ADR_TH):           rdata = WB_DAT_WIDTH'(th_shadow);
            WB_ADR_WIDTH'(ADR_INV):          rdata = WB_DAT_WIDTH'(inv_shadow);
            WB_ADR_WIDTH'(ADR_MODE):         rdata = WB_DAT_WIDTH'(mode_shadow);
            WB_ADR_WIDTH'(ADR_ACT_TH):       rdata = WB_DAT_WIDTH'(th_active_q);
            WB_ADR_WIDTH'(ADR_ACT_INV):      rdata = WB_DAT_WIDTH'(inv_active_q);
            WB_ADR_WIDTH'(ADR_ACT_MODE):     rdata = WB_DAT_WIDTH'(mode_active_q);
            default:                         rdata = '0;
        endcase
    end

    assign s_wb_dat_o     = rdata;
    assign out_param_th   = th_active_q;
    assign out_param_inv  = inv_active_q;
    assign out_param_mode = mode_active_q;
    assign out_update     = update_q;

    // Write-data bits and byte lanes beyond the widest register have no destination
    assign unused_ok = ^{s_wb_dat_i[WB_DAT_WIDTH-1:DATA_WIDTH], s_wb_sel_i[WB_SEL_WIDTH-1:1]};

endmodule
